pc_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control decoder.
- Holds the PC, issues word fetches on a req/ack instruction-memory port, and registers the returned instruction.
- Presents opcode/funct to the decoder and computes the next PC from the decoder's jump/branch outputs, the ALU zero flag and the fetched immediate fields.

---
 rtl/cpu_isa_pkg.sv | 12 +
 rtl/pc_next_calc.sv | 28 ++
 rtl/pc_fetch_unit.sv | 81 ++++++++
 tb/tb_pc_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA opcodes, the fetch NOP word and the fetch state encoding.
package cpu_isa_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_NOP = 6'b111111;
  localparam logic [5:0] FUNCT_JR = 6'b001000;
  localparam logic [31:0] NOP_WORD = {OP_NOP, 26'd0};
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_READY, S_FAULT} fetch_state_e;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC mux (jr > j/jal > taken branch > sequential).
module pc_next_calc
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [31:0]       instr,
  input  logic              jump,
  input  logic              branch_on_eq,
  input  logic              branch_on_neq,
  input  logic              zero,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] next_pc
);
  logic [5:0] opcode, funct;
  logic is_jr, is_j, taken;
  logic [ADDR_W-1:0] j_target, br_target;
  assign opcode = instr[31:26];
  assign funct = instr[5:0];
  assign is_jr = jump & (opcode == OP_RTYPE) & (funct == FUNCT_JR);
  assign is_j = jump & ((opcode == OP_J) | (opcode == OP_JAL));
  assign taken = ((opcode == OP_BEQ) & branch_on_eq & zero) |
                 ((opcode == OP_BNE) & branch_on_neq & ~zero);
  assign j_target = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
  assign br_target = pc_plus4 + ADDR_W'($signed({instr[15:0], 2'b00}));
  assign next_pc = is_jr ? jr_target : is_j ? j_target : taken ? br_target : pc_plus4;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, req/ack instruction fetch and next-PC selection.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned jr targets into a sticky FAULT state.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_WORD = cpu_isa_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              inc_pc,
  input  logic              stall,
  input  logic              jump,
  input  logic              branch_on_eq,
  input  logic              branch_on_neq,
  input  logic              zero,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fault
);
  import cpu_isa_pkg::*;
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, next_pc, target;
  logic [31:0] instr_q, instr_d;
  logic fetch_done, advance, misaligned;
  assign pc_plus4 = pc_q + ADDR_W'(4);
  pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
    .pc_plus4     (pc_plus4),
    .instr        (instr_q),
    .jump         (jump),
    .branch_on_eq (branch_on_eq),
    .branch_on_neq(branch_on_neq),
    .zero         (zero),
    .jr_target    (jr_target),
    .next_pc      (next_pc)
  );
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = |next_pc[1:0];
  assign target = next_pc;
  assign fault = state_q == S_FAULT;
`else
  assign misaligned = 1'b0;
  assign target = next_pc & ~ADDR_W'(3);
  assign fault = 1'b0;
`endif
  assign fetch_done = (state_q == S_FETCH) & imem_ack;
  assign advance = (state_q == S_READY) & inc_pc & ~stall;
  always_comb begin
    state_d = state_q == S_RESET ? S_FETCH :
              fetch_done ? S_READY :
              advance ? (misaligned ? S_FAULT : S_FETCH) : state_q;
    pc_d = advance ? target : pc_q;
    instr_d = fetch_done ? imem_rdata : advance ? NOP_WORD : instr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q <= RESET_PC;
      instr_q <= NOP_WORD;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
    end
  end
  assign imem_req = state_q == S_FETCH;
  assign imem_addr = pc_q;
  assign instr_valid = state_q == S_READY;
  assign instr = instr_q;
  assign opcode = instr_q[31:26];
  assign funct = instr_q[5:0];
  assign pc = pc_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table, hand-written corner sequences and a randomized run against a next-PC model.
module tb_pc_fetch_unit;
  localparam logic [31:0] NOP = 32'hFC00_0000;
  localparam logic [31:0] JR_WORD = 32'h0000_0008;
  logic clk = 1'b0;
  logic rst, imem_req, imem_ack, inc_pc, stall, jump, branch_on_eq, branch_on_neq, zero;
  logic instr_valid, fault;
  logic [31:0] imem_addr, imem_rdata, jr_target, instr, pc, pc_plus4;
  logic [5:0] opcode, funct;
  int n_pass = 0;
  int n_total = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inc_pc(inc_pc), .stall(stall), .jump(jump),
    .branch_on_eq(branch_on_eq), .branch_on_neq(branch_on_neq), .zero(zero),
    .jr_target(jr_target), .instr(instr), .opcode(opcode), .funct(funct),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        j, beq, bne, z;
    logic [31:0] jrt;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Next PC from the instruction-set rules, computed with plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
      input logic j, input logic beq, input logic bne, input logic z, input logic [31:0] t);
    logic [31:0] seq = p + 32'd4;
    int unsigned op = ins[31:26];
    if (j && op == 0 && ins[5:0] == 6'd8) return t & 32'hFFFF_FFFC;
    if (j && (op == 2 || op == 3)) return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    if ((op == 4 && beq && z) || (op == 5 && bne && !z))
      return seq + 32'($signed(ins[15:0])) * 32'd4;
    return seq;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0: return {6'd0, r[25:6], 6'b001000};
      1: return {6'd2, r[25:0]};
      2: return {6'd3, r[25:0]};
      3: return {6'd4, r[25:0]};
      4: return {6'd5, r[25:0]};
      default: return r;
    endcase
  endfunction

  // Called at a negedge while fetching; acks after dly cycles and checks the captured word.
  task automatic do_fetch(input logic [31:0] w, input logic [31:0] addr, input int dly);
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, addr);
    repeat (dly) begin
      @(negedge clk);
      chk("wait_addr", imem_addr, addr);
      chk("wait_valid", instr_valid, 1'b0);
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("ack_valid", instr_valid, 1'b1);
    chk("ack_instr", instr, w);
    chk("ack_req", imem_req, 1'b0);
  endtask

  // Called at a negedge in READY; stalls for some cycles, then advances.
  task automatic do_adv(input logic j, input logic beq, input logic bne, input logic z,
      input logic [31:0] jrt, input int stalls);
    jump = j;
    branch_on_eq = beq;
    branch_on_neq = bne;
    zero = z;
    jr_target = jrt;
    inc_pc = 1'b1;
    stall = stalls > 0;
    repeat (stalls) begin
      @(negedge clk);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_valid", instr_valid, 1'b1);
    end
    stall = 1'b0;
    @(negedge clk);
    inc_pc = 1'b0;
    jump = 1'b0;
    branch_on_eq = 1'b0;
    branch_on_neq = 1'b0;
    zero = 1'b0;
    jr_target = $urandom;
    chk("adv_nop", instr, NOP);
    chk("adv_valid", instr_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] mpc, mi, ni, exp, jrt;
    logic j, beq, bne, z;
    vecs.push_back('{32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0014});
    vecs.push_back('{32'h0000_0040, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0040});
    vecs.push_back('{32'h0000_0040, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0044});
    vecs.push_back('{32'h3000_0000, 32'h0C00_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3000_0400});
    vecs.push_back('{32'h0000_0100, 32'h1400_0003, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0110});
    vecs.push_back('{32'h0000_0100, 32'h1400_0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0104});
    vecs.push_back('{32'h0000_0060, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0064});
    vecs.push_back('{32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000});
    vecs.push_back('{32'hFFFF_FFFC, 32'h0800_0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004});
    vecs.push_back('{32'h0000_0040, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_003C});
    vecs.push_back('{32'h0000_0500, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h900, 32'h0000_0504});
    vecs.push_back('{32'h0000_0600, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h900, 32'h0000_0900});
`ifndef FETCH_MISALIGN_TRAP_EN
    vecs.push_back('{32'h0000_0200, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h203, 32'h0000_0200});
`endif
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    inc_pc = 1'b0;
    stall = 1'b0;
    jump = 1'b0;
    branch_on_eq = 1'b0;
    branch_on_neq = 1'b0;
    zero = 1'b0;
    jr_target = '0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fault", fault, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_req", imem_req, 1'b1);
    chk("t1_addr", imem_addr, 32'h0);
    inc_pc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_wait_req", imem_req, 1'b1);
    chk("t1_wait_valid", instr_valid, 1'b0);
    chk("t1_inc_ignored", pc, 32'h0);
    inc_pc = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0020;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_opcode", 32'(opcode), 32'h0);
    chk("t1_funct", 32'(funct), 32'h20);
    chk("t1_plus4", pc_plus4, 32'h4);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("stray_ack_instr", instr, 32'h0000_0020);
    chk("stray_ack_valid", instr_valid, 1'b1);
    do_adv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    do_fetch(JR_WORD, 32'h4, 1);
    foreach (vecs[i]) begin
      do_adv(1'b1, 1'b0, 1'b0, 1'b0, vecs[i].pc, 0);
      do_fetch(vecs[i].instr, vecs[i].pc, 1);
      chk("vec_pc", pc, vecs[i].pc);
      chk("vec_plus4", pc_plus4, vecs[i].pc + 32'd4);
      do_adv(vecs[i].j, vecs[i].beq, vecs[i].bne, vecs[i].z, vecs[i].jrt, 0);
      do_fetch(JR_WORD, vecs[i].exp, 0);
    end
    do_adv(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 3);
    do_fetch(JR_WORD, 32'h200, 0);
    mpc = 32'h200;
    mi = JR_WORD;
    for (int k = 0; k < 150; k++) begin
      j = 1'($urandom_range(0, 1));
      beq = 1'($urandom_range(0, 1));
      bne = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      jrt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      jrt = jrt & 32'hFFFF_FFFC;
`endif
      exp = model_next(mpc, mi, j, beq, bne, z, jrt);
      if ($urandom_range(0, 3) == 0) begin
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rnd_stray_ack", instr, mi);
      end
      do_adv(j, beq, bne, z, jrt, $urandom_range(0, 2));
      ni = rand_instr();
      do_fetch(ni, exp, $urandom_range(0, 3));
      chk("rnd_pc", pc, exp);
      mpc = exp;
      mi = ni;
    end
    do_adv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    do_fetch(JR_WORD, mpc + 32'd4, 0);
    do_adv(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 0);
    chk("mid_req", imem_req, 1'b1);
    chk("mid_addr", imem_addr, 32'h80);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_instr", instr, NOP);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    do_fetch(JR_WORD, 32'h0, 0);
    do_adv(1'b1, 1'b0, 1'b0, 1'b0, 32'h202, 0);
    repeat (3) begin
      chk("trap_fault", fault, 1'b1);
      chk("trap_req", imem_req, 1'b0);
      chk("trap_valid", instr_valid, 1'b0);
      chk("trap_pc", pc, 32'h202);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("trap_clear", fault, 1'b0);
    @(negedge clk);
    rst = 1'b0;
`else
    do_fetch(JR_WORD, 32'h0, 0);
    chk("nofault", fault, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
